// File: rtl/rvv_backend_rs_credit_ctrl_pkg.sv
// Shared constants for the reservation-station credit tracker: RS indices and default depths.
package rvv_backend_rs_credit_ctrl_pkg;

  localparam int unsigned NUM_RS    = 5;

  localparam int unsigned RS_ALU    = 0;
  localparam int unsigned RS_PMTRDT = 1;
  localparam int unsigned RS_MUL    = 2;
  localparam int unsigned RS_DIV    = 3;
  localparam int unsigned RS_LSU    = 4;

  localparam int unsigned DEF_NUM_DP_UOP   = 2;
  localparam int unsigned DEF_NUM_POP      = 2;
  localparam int unsigned DEF_ALU_DEPTH    = 8;
  localparam int unsigned DEF_PMTRDT_DEPTH = 4;
  localparam int unsigned DEF_MUL_DEPTH    = 4;
  localparam int unsigned DEF_DIV_DEPTH    = 4;
  localparam int unsigned DEF_LSU_DEPTH    = 8;

endpackage

// File: rtl/rvv_backend_rs_credit.sv
// Free-entry counter for one reservation station; ready is derived from registered credit only.
module rvv_backend_rs_credit #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned NUM_DP_UOP = 2,
  parameter int unsigned NUM_POP    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NUM_DP_UOP-1:0] push,
  input  logic [NUM_POP-1:0]    pop,
  output logic [NUM_DP_UOP-1:0] ready,
  output logic                  err
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned SumW = CntW + 2;
  localparam logic [CntW-1:0]        DepthC = CntW'(DEPTH);
  localparam logic signed [SumW-1:0] DepthS = SumW'(DEPTH);

  logic [CntW-1:0]        free_q, free_d;
  logic                   err_q, err_d;
  logic signed [SumW-1:0] push_cnt, pop_cnt, free_next;
  logic                   push_bad;

  always_comb begin
    push_cnt = '0;
    pop_cnt  = '0;
    push_bad = 1'b0;
    for (int i = 0; i < NUM_DP_UOP; i++) begin
      push_cnt = push_cnt + $signed(SumW'(push[i]));
      // Each slot is checked against its own threshold, not a prefix of earlier slots.
      if (push[i] && !(int'(free_q) > i)) push_bad = 1'b1;
    end
    for (int i = 0; i < NUM_POP; i++) begin
      pop_cnt = pop_cnt + $signed(SumW'(pop[i]));
    end
    free_next = $signed(SumW'(free_q)) - push_cnt + pop_cnt;
  end

  always_comb begin
    free_d = free_q;
    err_d  = err_q;
    if (flush) begin
      free_d = DepthC;
    end else if (push_bad || (free_next < 0)) begin
      free_d = '0;
      err_d  = 1'b1;
    end else if (free_next > DepthS) begin
      free_d = DepthC;
      err_d  = 1'b1;
    end else begin
      free_d = free_next[CntW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q <= DepthC;
      err_q  <= 1'b0;
    end else begin
      free_q <= free_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DP_UOP; i++) begin
      ready[i] = (int'(free_q) > i) && !flush;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/rvv_backend_rs_credit_ctrl.sv
// Credit-based ready generation for the ALU, PMTRDT, MUL, DIV and LSU reservation stations.
module rvv_backend_rs_credit_ctrl
  import rvv_backend_rs_credit_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DP_UOP   = DEF_NUM_DP_UOP,
  parameter int unsigned NUM_POP      = DEF_NUM_POP,
  parameter int unsigned ALU_DEPTH    = DEF_ALU_DEPTH,
  parameter int unsigned PMTRDT_DEPTH = DEF_PMTRDT_DEPTH,
  parameter int unsigned MUL_DEPTH    = DEF_MUL_DEPTH,
  parameter int unsigned DIV_DEPTH    = DEF_DIV_DEPTH,
  parameter int unsigned LSU_DEPTH    = DEF_LSU_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trap_flush_rvv,
  input  logic [NUM_DP_UOP-1:0] rs_valid_dp2alu,
  input  logic [NUM_DP_UOP-1:0] rs_valid_dp2pmtrdt,
  input  logic [NUM_DP_UOP-1:0] rs_valid_dp2mul,
  input  logic [NUM_DP_UOP-1:0] rs_valid_dp2div,
  input  logic [NUM_DP_UOP-1:0] rs_valid_dp2lsu,
  input  logic [NUM_POP-1:0]    pop_alu,
  input  logic [NUM_POP-1:0]    pop_pmtrdt,
  input  logic [NUM_POP-1:0]    pop_mul,
  input  logic [NUM_POP-1:0]    pop_div,
  input  logic [NUM_POP-1:0]    pop_lsu,
  output logic [NUM_DP_UOP-1:0] rs_ready_alu2dp,
  output logic [NUM_DP_UOP-1:0] rs_ready_pmtrdt2dp,
  output logic [NUM_DP_UOP-1:0] rs_ready_mul2dp,
  output logic [NUM_DP_UOP-1:0] rs_ready_div2dp,
  output logic [NUM_DP_UOP-1:0] rs_ready_lsu2dp,
  output logic [NUM_RS-1:0]     credit_err
);

  rvv_backend_rs_credit #(
    .DEPTH      (ALU_DEPTH),
    .NUM_DP_UOP (NUM_DP_UOP),
    .NUM_POP    (NUM_POP)
  ) u_alu (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (trap_flush_rvv),
    .push  (rs_valid_dp2alu),
    .pop   (pop_alu),
    .ready (rs_ready_alu2dp),
    .err   (credit_err[RS_ALU])
  );

  rvv_backend_rs_credit #(
    .DEPTH      (PMTRDT_DEPTH),
    .NUM_DP_UOP (NUM_DP_UOP),
    .NUM_POP    (NUM_POP)
  ) u_pmtrdt (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (trap_flush_rvv),
    .push  (rs_valid_dp2pmtrdt),
    .pop   (pop_pmtrdt),
    .ready (rs_ready_pmtrdt2dp),
    .err   (credit_err[RS_PMTRDT])
  );

  rvv_backend_rs_credit #(
    .DEPTH      (MUL_DEPTH),
    .NUM_DP_UOP (NUM_DP_UOP),
    .NUM_POP    (NUM_POP)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (trap_flush_rvv),
    .push  (rs_valid_dp2mul),
    .pop   (pop_mul),
    .ready (rs_ready_mul2dp),
    .err   (credit_err[RS_MUL])
  );

  rvv_backend_rs_credit #(
    .DEPTH      (DIV_DEPTH),
    .NUM_DP_UOP (NUM_DP_UOP),
    .NUM_POP    (NUM_POP)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (trap_flush_rvv),
    .push  (rs_valid_dp2div),
    .pop   (pop_div),
    .ready (rs_ready_div2dp),
    .err   (credit_err[RS_DIV])
  );

  rvv_backend_rs_credit #(
    .DEPTH      (LSU_DEPTH),
    .NUM_DP_UOP (NUM_DP_UOP),
    .NUM_POP    (NUM_POP)
  ) u_lsu (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (trap_flush_rvv),
    .push  (rs_valid_dp2lsu),
    .pop   (pop_lsu),
    .ready (rs_ready_lsu2dp),
    .err   (credit_err[RS_LSU])
  );

endmodule

// File: tb/tb_rvv_backend_rs_credit_ctrl.sv
// Self-checking bench: directed table and sequences plus randomized traffic against a credit model.
module tb_rvv_backend_rs_credit_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush_s = 1'b0;
  logic [1:0] push_s [5];
  logic [1:0] pop_s  [5];
  logic [1:0] rdy    [5];
  logic [1:0] rdy_alu, rdy_pmt, rdy_mul, rdy_div, rdy_lsu;
  logic [4:0] credit_err;

  int checks = 0;
  int errors = 0;

  // Reference model: free entries and sticky error per RS
  int         dep [5];
  int         free_m [5];
  logic [4:0] err_m;

  typedef struct packed {
    logic [1:0] push;
    logic [1:0] pop;
    logic       flush;
    logic [1:0] exp_ready;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  rvv_backend_rs_credit_ctrl #(
    .NUM_DP_UOP   (2),
    .NUM_POP      (2),
    .ALU_DEPTH    (8),
    .PMTRDT_DEPTH (4),
    .MUL_DEPTH    (4),
    .DIV_DEPTH    (4),
    .LSU_DEPTH    (8)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .trap_flush_rvv     (flush_s),
    .rs_valid_dp2alu    (push_s[0]),
    .rs_valid_dp2pmtrdt (push_s[1]),
    .rs_valid_dp2mul    (push_s[2]),
    .rs_valid_dp2div    (push_s[3]),
    .rs_valid_dp2lsu    (push_s[4]),
    .pop_alu            (pop_s[0]),
    .pop_pmtrdt         (pop_s[1]),
    .pop_mul            (pop_s[2]),
    .pop_div            (pop_s[3]),
    .pop_lsu            (pop_s[4]),
    .rs_ready_alu2dp    (rdy_alu),
    .rs_ready_pmtrdt2dp (rdy_pmt),
    .rs_ready_mul2dp    (rdy_mul),
    .rs_ready_div2dp    (rdy_div),
    .rs_ready_lsu2dp    (rdy_lsu),
    .credit_err         (credit_err)
  );

  assign rdy[0] = rdy_alu;
  assign rdy[1] = rdy_pmt;
  assign rdy[2] = rdy_mul;
  assign rdy[3] = rdy_div;
  assign rdy[4] = rdy_lsu;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_ready(input int r);
    logic [1:0] m;
    for (int i = 0; i < 2; i++) m[i] = (free_m[r] > i) && !flush_s;
    return m;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 5; r++) free_m[r] = dep[r];
    err_m = '0;
  endtask

  task automatic model_next();
    for (int r = 0; r < 5; r++) begin
      if (flush_s) begin
        free_m[r] = dep[r];
      end else begin
        bit under = 0;
        int nf;
        for (int i = 0; i < 2; i++) if (push_s[r][i] && !(free_m[r] > i)) under = 1;
        nf = free_m[r] - $countones(push_s[r]) + $countones(pop_s[r]);
        if (under || nf < 0) begin
          free_m[r] = 0;
          err_m[r]  = 1'b1;
        end else if (nf > dep[r]) begin
          free_m[r] = dep[r];
          err_m[r]  = 1'b1;
        end else begin
          free_m[r] = nf;
        end
      end
    end
  endtask

  task automatic clear_inputs();
    for (int r = 0; r < 5; r++) begin
      push_s[r] = 2'b00;
      pop_s[r]  = 2'b00;
    end
    flush_s = 1'b0;
  endtask

  task automatic check_now();
    for (int r = 0; r < 5; r++) chk($sformatf("ready_rs%0d", r), rdy[r], model_ready(r));
    chk("credit_err", credit_err, err_m);
  endtask

  task automatic advance();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    check_now();
    advance();
  endtask

  initial begin
    dep = '{8, 4, 4, 4, 8};
    clear_inputs();
    model_reset();

    // ALU fill/drain: {push, pop, flush, ready seen in that cycle}
    tbl[0] = '{2'b11, 2'b00, 1'b0, 2'b11};
    tbl[1] = '{2'b11, 2'b00, 1'b0, 2'b11};
    tbl[2] = '{2'b11, 2'b00, 1'b0, 2'b11};
    tbl[3] = '{2'b11, 2'b00, 1'b0, 2'b11};
    tbl[4] = '{2'b00, 2'b01, 1'b0, 2'b00};
    tbl[5] = '{2'b00, 2'b11, 1'b0, 2'b01};
    tbl[6] = '{2'b01, 2'b00, 1'b1, 2'b00};
    tbl[7] = '{2'b00, 2'b00, 1'b0, 2'b11};

    #12;
    chk("reset_err_async", credit_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      push_s[0] = tbl[k].push;
      pop_s[0]  = tbl[k].pop;
      flush_s   = tbl[k].flush;
      @(negedge clk);
      chk($sformatf("tbl_alu_ready_%0d", k), rdy_alu, tbl[k].exp_ready);
      check_now();
      advance();
    end
    clear_inputs();

    // DIV: free 4 -> 1, then push+pop nets out, then a lone push exhausts it
    push_s[3] = 2'b01;
    repeat (3) step();
    pop_s[3] = 2'b01;
    @(negedge clk);
    chk("div_free1_ready", rdy_div, 2'b01);
    check_now();
    advance();
    pop_s[3] = 2'b00;
    @(negedge clk);
    chk("div_net_zero_ready", rdy_div, 2'b01);
    check_now();
    advance();
    clear_inputs();
    @(negedge clk);
    chk("div_empty_ready", rdy_div, 2'b00);
    chk("div_no_err", credit_err[3], 0);
    advance();

    // MUL: drain to zero, then an illegal push sets a sticky error
    push_s[2] = 2'b11;
    repeat (2) step();
    push_s[2] = 2'b01;
    step();
    clear_inputs();
    @(negedge clk);
    chk("mul_err_set", credit_err[2], 1);
    chk("mul_clamped_ready", rdy_mul, 2'b00);
    advance();
    pop_s[2] = 2'b11;
    repeat (2) step();
    clear_inputs();
    @(negedge clk);
    chk("mul_err_sticky", credit_err[2], 1);
    chk("mul_refilled_ready", rdy_mul, 2'b11);
    advance();

    // PMTRDT: extra pop at full credit overflows and clamps
    pop_s[1] = 2'b01;
    step();
    clear_inputs();
    @(negedge clk);
    chk("pmt_overflow_err", credit_err[1], 1);
    chk("pmt_clamped_ready", rdy_pmt, 2'b11);
    advance();
    push_s[1] = 2'b11;
    repeat (2) step();
    clear_inputs();
    @(negedge clk);
    chk("pmt_clamp_at_depth", rdy_pmt, 2'b00);
    advance();

    // LSU: reach free=3 with traffic, then a one-cycle flush
    push_s[4] = 2'b11;
    step();
    pop_s[4] = 2'b01;
    step();
    pop_s[4] = 2'b00;
    step();
    push_s[4] = 2'b11;
    pop_s[4]  = 2'b01;
    flush_s   = 1'b1;
    @(negedge clk);
    chk("lsu_flush_ready", rdy_lsu, 2'b00);
    chk("alu_flush_ready", rdy_alu, 2'b00);
    check_now();
    advance();
    clear_inputs();
    @(negedge clk);
    chk("lsu_after_flush", rdy_lsu, 2'b11);
    chk("err_survives_flush", credit_err, 5'b00110);
    check_now();
    advance();
    flush_s = 1'b1;
    repeat (3) step();
    clear_inputs();
    step();

    // Randomized traffic, mostly legal with occasional violations and flushes
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 5; r++) begin
        logic [1:0] p, q;
        int occ;
        p = 2'($urandom);
        q = 2'($urandom);
        if ($urandom_range(15) != 0) p = p & model_ready(r);
        occ = dep[r] - free_m[r];
        if ($urandom_range(15) != 0 && $countones(q) > occ) q = (occ >= 1) ? 2'b01 : 2'b00;
        push_s[r] = p;
        pop_s[r]  = q;
      end
      flush_s = ($urandom_range(19) == 0);
      step();
      if (n == 200) begin
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    end

    // Asynchronous reset between clock edges
    push_s[0] = 2'b11;
    push_s[4] = 2'b11;
    push_s[2] = 2'b11;
    step();
    clear_inputs();
    push_s[2] = 2'b01;
    step();
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_alu", rdy_alu, 2'b11);
    chk("async_rst_mul", rdy_mul, 2'b11);
    chk("async_rst_lsu", rdy_lsu, 2'b11);
    chk("async_rst_err", credit_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
